// File: rtl/drac_pkg.sv
// Shared core types for the vector functional units.
// SIMD op/element-width encodings and helpers used across the datapath.
package drac_pkg;

    typedef enum logic [4:0] {
        VADD     = 5'd0,
        VSUB     = 5'd1,
        VAND     = 5'd2,
        VOR      = 5'd3,
        VXOR     = 5'd4,
        VMIN     = 5'd5,
        VMINU    = 5'd6,
        VMAX     = 5'd7,
        VMAXU    = 5'd8,
        VMSEQ    = 5'd9,
        VSLL     = 5'd10,
        VSRL     = 5'd11,
        VSRA     = 5'd12,
        VMUL     = 5'd13,
        VMULH    = 5'd14,
        VMULHU   = 5'd15,
        VMULHSU  = 5'd16,
        VID      = 5'd17,
        VMV      = 5'd18,
        VREDSUM  = 5'd19,
        VNOP     = 5'd31
    } instr_type_t;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_t;

    typedef logic [2:0] fu_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } red_state_t;

    localparam int unsigned DEFAULT_SIMD_FU_LAT = 3;

    function automatic logic [6:0] sew_bits(input sew_t s);
        return 7'd8 << s;
    endfunction

    function automatic logic [63:0] sew_mask(input sew_t s);
        if (s == SEW_64) return '1;
        return (64'd1 << sew_bits(s)) - 64'd1;
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One 64-bit SIMD lane: every element op except the cross-lane reduction.
// Elements are processed with shift/mask so one loop serves all widths.
module simd_lane_alu
    import drac_pkg::*;
#(
    parameter int unsigned NLANES = 1,
    parameter int unsigned LANE   = 0
) (
    input  instr_type_t op_i,
    input  sew_t        sew_i,
    input  fu_id_t      fu_id_i,
    input  logic [63:0] vs1_i,
    input  logic [63:0] vs2_i,
    output logic [63:0] vd_o
);

    function automatic logic [63:0] elem_op(
        input instr_type_t op,
        input sew_t        sew,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] idx
    );
        logic [6:0]   w;
        logic [5:0]   msb;
        logic [63:0]  m, sa, sb, sh, r;
        logic [127:0] pa, pb, prod;
        w   = sew_bits(sew);
        msb = 6'(w - 7'd1);
        m   = sew_mask(sew);
        sa  = a[msb] ? (a | ~m) : a;
        sb  = b[msb] ? (b | ~m) : b;
        sh  = b & {58'd0, msb};
        // 128-bit modular products cover every signedness mix
        pa  = {64'd0, a};
        pb  = {64'd0, b};
        if (op == VMULH || op == VMULHSU) pa = {{64{sa[63]}}, sa};
        if (op == VMULH) pb = {{64{sb[63]}}, sb};
        prod = pa * pb;
        r = '0;
        case (op)
            VADD:    r = a + b;
            VSUB:    r = a - b;
            VAND:    r = a & b;
            VOR:     r = a | b;
            VXOR:    r = a ^ b;
            VMIN:    r = ($signed(sa) < $signed(sb)) ? a : b;
            VMINU:   r = (a < b) ? a : b;
            VMAX:    r = ($signed(sa) < $signed(sb)) ? b : a;
            VMAXU:   r = (a < b) ? b : a;
            VMSEQ:   r = (a == b) ? m : '0;
            VSLL:    r = a << sh[5:0];
            VSRL:    r = a >> sh[5:0];
            VSRA:    r = 64'($signed(sa) >>> sh[5:0]);
            VMUL:    r = prod[63:0];
            VMULH,
            VMULHU,
            VMULHSU: r = 64'(prod >> w);
            VID:     r = idx;
            VMV:     r = b;
            default: r = '0;
        endcase
        return r & m;
    endfunction

    logic [6:0]  w;
    logic [63:0] m, base, a, b;
    logic [3:0]  n;
    logic [5:0]  sft;

    always_comb begin
        vd_o = '0;
        w    = sew_bits(sew_i);
        m    = sew_mask(sew_i);
        n    = 4'd8 >> sew_i;
        base = (64'(fu_id_i) * 64'(NLANES) + 64'(LANE)) * 64'(n);
        a    = '0;
        b    = '0;
        sft  = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < int'(n)) begin
                sft  = 6'(j * int'(w));
                a    = (vs2_i >> sft) & m;
                b    = (vs1_i >> sft) & m;
                vd_o = vd_o | (elem_op(op_i, sew_i, a, b, base + 64'(j)) << sft);
            end
        end
    end

endmodule

// File: rtl/simd_fu_pipe.sv
// Pipelined SIMD functional unit: lane ALUs, VREDSUM accumulator FSM,
// LAT-deep result pipeline with a global valid/ready stall.
module simd_fu_pipe
    import drac_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LAT    = DEFAULT_SIMD_FU_LAT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              kill_i,
    input  fu_id_t            fu_id_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  instr_type_t       op_i,
    input  sew_t              sew_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] data_vs1_i,
    input  logic [DATA_W-1:0] data_vs2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_vd_o
);

    localparam int unsigned NL = DATA_W / 64;

    logic [DATA_W-1:0] alu_res;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        simd_lane_alu #(
            .NLANES (NL),
            .LANE   (l)
        ) u_lane (
            .op_i    (op_i),
            .sew_i   (sew_i),
            .fu_id_i (fu_id_i),
            .vs1_i   (data_vs1_i[l*64 +: 64]),
            .vs2_i   (data_vs2_i[l*64 +: 64]),
            .vd_o    (alu_res[l*64 +: 64])
        );
    end

    logic              stall, accept, is_red;
    logic [6:0]        w;
    logic [63:0]       m, vsum;
    logic [DATA_W-1:0] chunk;

    assign stall   = valid_o && !ready_i;
    assign ready_o = !stall;
    assign accept  = valid_i && ready_o && !kill_i;
    assign is_red  = (op_i == VREDSUM);
    assign w       = sew_bits(sew_i);
    assign m       = sew_mask(sew_i);

    // Sum of every vs2 element across all lanes, wrapped to SEW
    always_comb begin
        vsum  = '0;
        chunk = '0;
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            if (i < int'(DATA_W) / int'(w)) begin
                chunk = data_vs2_i >> (i * int'(w));
                vsum  = vsum + (chunk[63:0] & m);
            end
        end
        vsum = vsum & m;
    end

    red_state_t        state_q, state_d;
    logic [63:0]       acc_q, acc_d;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        in_valid = 1'b0;
        in_data  = alu_res;
        if (kill_i) begin
            state_d = IDLE;
        end else if (accept && is_red) begin
            acc_d = (state_q == IDLE || first_i) ?
                    (data_vs1_i[63:0] & m) : acc_q;
            acc_d    = (acc_d + vsum) & m;
            state_d  = last_i ? IDLE : ACCUM;
            in_valid = last_i;
            in_data  = DATA_W'(acc_d);
        end else if (accept) begin
            in_valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    logic [LAT-1:0]    vld_q;
    logic [DATA_W-1:0] dat_q [LAT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < int'(LAT); k++) dat_q[k] <= '0;
        end else if (kill_i) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int k = 1; k < int'(LAT); k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign valid_o   = vld_q[LAT-1];
    assign data_vd_o = dat_q[LAT-1];

endmodule
